mprj_checkpoint_monitor: RTL

//  Synthesizable progress monitor for user-project bring-up. Watches a checkpoint field and a done field

---
 rtl/mprj_checkpoint_monitor_pkg.sv | 26 ++
 rtl/ckpt_sync_filter.sv | 67 ++++++
 rtl/mprj_checkpoint_monitor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mprj_checkpoint_monitor_pkg.sv
// ============================================================================
// Module   : mprj_checkpoint_monitor_pkg
// Brief    : State encodings and fail-cause codes for the checkpoint monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mprj_checkpoint_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_PASS       = 3'd4,
        ST_FAIL       = 3'd5
    } mon_state_t;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd1;
    localparam logic [1:0] CAUSE_REGRESS    = 2'd2;
    localparam logic [1:0] CAUSE_SKIP_START = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ckpt_sync_filter.sv
// ============================================================================
// Module   : ckpt_sync_filter
// Brief    : Two-flop synchroniser followed by a stability filter; a value is
//            accepted after STABLE_CYCLES identical synced samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ckpt_sync_filter #(
    parameter int W             = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [W-1:0] din,
    output logic [W-1:0] value,
    output logic         accept
);

    localparam int             SC_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

    logic [W-1:0]    meta;
    logic [W-1:0]    synced;
    logic [W-1:0]    cand;
    logic [W-1:0]    cand_nx;
    logic [SC_W-1:0] run;
    logic [SC_W-1:0] run_nx;
    logic            take;

    // run counts consecutive identical synced samples, including the current one
    always_comb begin
        cand_nx = cand;
        run_nx  = run;
        if (synced != cand) begin
            cand_nx = synced;
            run_nx  = SC_ONE;
        end else if (run < SC_MAX) begin
            run_nx = run + SC_ONE;
        end
        take = (run_nx == SC_MAX) && (cand_nx != value);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meta   <= '0;
            synced <= '0;
            cand   <= '0;
            run    <= '0;
            value  <= '0;
            accept <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
            cand   <= cand_nx;
            run    <= run_nx;
            accept <= take;
            if (take) begin
                value <= cand_nx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mprj_checkpoint_monitor.sv
// ============================================================================
// Module   : mprj_checkpoint_monitor
// Brief    : Firmware progress monitor: start code -> monotonic progress ->
//            end code -> done, with sticky pass/fail and elapsed cycles.
//            Optional checkpoint log FIFO enabled by macro CKPT_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mprj_checkpoint_monitor
    import mprj_checkpoint_monitor_pkg::*;
#(
    parameter int FIELD_W        = 6,
    parameter int START_CODE     = 0,
    parameter int END_CODE       = 50,
    parameter int DONE_W         = 2,
    parameter int DONE_VAL       = 0,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int LOG_DEPTH      = 8,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       arm_i,
    input  logic [FIELD_W-1:0]         ckpt_i,
    input  logic [DONE_W-1:0]          done_i,
    output logic [2:0]                 state_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [1:0]                 fail_cause_o,
    output logic [FIELD_W-1:0]         last_ckpt_o,
    output logic [CNT_W-1:0]           cycle_cnt_o,
    input  logic                       log_rd_i,
    output logic [FIELD_W+CNT_W-1:0]   log_data_o,
    output logic                       log_empty_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

    mon_state_t          state, state_nx;
    logic [1:0]          cause, cause_nx;
    logic [FIELD_W-1:0]  last, last_nx;
    logic [FIELD_W-1:0]  arm_val, arm_val_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
    logic [FIELD_W-1:0]  ckpt_val;
    logic                ckpt_stb;
    logic [DONE_W-1:0]   done_val;
    logic                done_stb_unused;
    logic                log_push;

    ckpt_sync_filter #(.W(FIELD_W), .STABLE_CYCLES(STABLE_CYCLES)) u_ckpt_filter (
        .clock  (clock),
        .resetb (resetb),
        .din    (ckpt_i),
        .value  (ckpt_val),
        .accept (ckpt_stb)
    );

    ckpt_sync_filter #(.W(DONE_W), .STABLE_CYCLES(STABLE_CYCLES)) u_done_filter (
        .clock  (clock),
        .resetb (resetb),
        .din    (done_i),
        .value  (done_val),
        .accept (done_stb_unused)
    );

    // Priority inside active states: timeout, then regression, then progress
    always_comb begin
        state_nx   = state;
        cause_nx   = cause;
        last_nx    = last;
        arm_val_nx = arm_val;
        cnt_nx     = cnt;
        log_push   = 1'b0;
        cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
        if (!arm_i) begin
            state_nx   = ST_IDLE;
            cause_nx   = CAUSE_NONE;
            last_nx    = '0;
            arm_val_nx = '0;
            cnt_nx     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx   = ST_WAIT_START;
                    arm_val_nx = ckpt_val;
                end
                ST_WAIT_START, ST_RUNNING, ST_WAIT_DONE: begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= CNT_TO) begin
                        state_nx = ST_FAIL;
                        cause_nx = CAUSE_TIMEOUT;
                    end else if (state == ST_WAIT_START) begin
                        if (ckpt_val == FIELD_W'(START_CODE)) begin
                            state_nx = ST_RUNNING;
                            last_nx  = ckpt_val;
                        end else if (ckpt_val != arm_val) begin
                            state_nx = ST_FAIL;
                            cause_nx = CAUSE_SKIP_START;
                        end
                    end else if (state == ST_RUNNING) begin
                        if (ckpt_stb) begin
                            if (ckpt_val < last) begin
                                state_nx = ST_FAIL;
                                cause_nx = CAUSE_REGRESS;
                            end else begin
                                last_nx  = ckpt_val;
                                log_push = 1'b1;
                                if (ckpt_val == FIELD_W'(END_CODE)) begin
                                    state_nx = ST_WAIT_DONE;
                                end
                            end
                        end
                    end else begin
                        if (ckpt_stb) begin
                            last_nx  = ckpt_val;
                            log_push = 1'b1;
                        end
                        if (done_val == DONE_W'(DONE_VAL)) begin
                            state_nx = ST_PASS;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= ST_IDLE;
            cause   <= CAUSE_NONE;
            last    <= '0;
            arm_val <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            cause   <= cause_nx;
            last    <= last_nx;
            arm_val <= arm_val_nx;
            cnt     <= cnt_nx;
        end
    end

    assign state_o      = state;
    assign pass_o       = (state == ST_PASS);
    assign fail_o       = (state == ST_FAIL);
    assign fail_cause_o = cause;
    assign last_ckpt_o  = last;
    assign cycle_cnt_o  = cnt;

`ifdef CKPT_LOG_EN
    localparam int              PTR_W     = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(LOG_DEPTH);

    logic [FIELD_W+CNT_W-1:0] log_mem [LOG_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W:0]           level;
    logic                     pop_ok;
    logic                     push_ok;
    logic                     unused_done;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts then
    assign pop_ok      = log_rd_i && (level != '0);
    assign push_ok     = log_push && ((level != LVL_FULL) || pop_ok);
    assign log_data_o  = log_mem[rd_ptr];
    assign log_empty_o = (level == '0);
    assign unused_done = done_stb_unused;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (!arm_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            log_mem[wr_ptr] <= {ckpt_val, cnt};
        end
    end
`else
    logic unused_log;

    assign log_data_o  = '0;
    assign log_empty_o = 1'b1;
    assign unused_log  = ^{log_rd_i, log_push, done_stb_unused};
`endif

endmodule

`default_nettype wire
